// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : two-master round-robin memory arbiter with bus lock and
//               forced release after LOCK_MAX locked cycles.
// Revision    : 1.0
// ============================================================================
module mem_arbiter #(
  parameter int LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_r_en,
  output logic [31:0] mem_r_addr,
  input  logic [31:0] mem_r_data,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data
);

  localparam int LCNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                rtag_vld_q, rtag_vld_d;
  logic                rtag_own_q, rtag_own_d;

  logic                gnt0, gnt1, any_gnt, sel;
  logic                sel_we, sel_lock, own_idx, own_lock;
  logic [31:0]         sel_addr, sel_wdata;

  // Grants are combinational and forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (m0_req && m1_req) begin
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        OWN0:    gnt0 = m0_req;
        OWN1:    gnt1 = m1_req;
        default: ;
      endcase
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel       = gnt1;
  assign sel_we    = sel ? m1_we    : m0_we;
  assign sel_lock  = sel ? m1_lock  : m0_lock;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign own_idx   = (state_q == OWN1);
  assign own_lock  = own_idx ? m1_lock : m0_lock;

  assign m0_gnt     = gnt0;
  assign m1_gnt     = gnt1;
  assign mem_r_en   = any_gnt & !sel_we;
  assign mem_w_en   = any_gnt & sel_we;
  assign mem_r_addr = mem_r_en ? sel_addr  : 32'h0;
  assign mem_w_addr = mem_w_en ? sel_addr  : 32'h0;
  assign mem_w_data = mem_w_en ? sel_wdata : 32'h0;

  assign m0_rvalid = rtag_vld_q & !rtag_own_q;
  assign m1_rvalid = rtag_vld_q &  rtag_own_q;
  assign m0_rdata  = m0_rvalid ? mem_r_data : 32'h0;
  assign m1_rdata  = m1_rvalid ? mem_r_data : 32'h0;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lcnt_d     = lcnt_q;
    rtag_vld_d = mem_r_en;
    rtag_own_d = sel;
    case (state_q)
      IDLE: begin
        if (any_gnt) begin
          last_d = sel;
          // A lock window of one cycle is already spent by this grant.
          if (sel_lock && (LOCK_MAX > 1)) begin
            state_d = sel ? OWN1 : OWN0;
            lcnt_d  = LCNT_W'(1);
          end
        end
      end
      OWN0, OWN1: begin
        if (lcnt_q != LCNT_W'(LOCK_MAX)) lcnt_d = lcnt_q + 1'b1;
        // Release on lock drop or when the window fills, handing priority away.
        if (!own_lock || (lcnt_d == LCNT_W'(LOCK_MAX))) begin
          state_d = IDLE;
          lcnt_d  = '0;
          last_d  = own_idx;
        end
      end
      default: begin
        state_d = IDLE;
        lcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lcnt_q     <= '0;
      rtag_vld_q <= 1'b0;
      rtag_own_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lcnt_q     <= lcnt_d;
      rtag_vld_q <= rtag_vld_d;
      rtag_own_q <= rtag_own_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter (LOCK_MAX=4).
// Revision       : 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_r_en, mem_w_en;
  logic [31:0] mem_r_addr, mem_r_data, mem_w_addr, mem_w_data;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, data = address ^ KEY, junk otherwise.
  always @(posedge clk) begin
    if (mem_r_en) mem_r_data <= mem_r_addr ^ KEY;
    else          mem_r_data <= 32'hFFFF_FFFF;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    clear_inputs();
    m0_req = 1; m1_req = 1; m0_addr = 32'h55; m1_addr = 32'h66;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt got=%0b exp=0", m0_gnt); end
    checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt got=%0b exp=0", m1_gnt); end
    checks++; if (mem_r_en !== 1'b0) begin errors++; $display("FAIL rst_mem_r_en got=%0b exp=0", mem_r_en); end
    checks++; if (mem_r_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_r_addr got=%h exp=0", mem_r_addr); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%0b%0b exp=00", m0_rvalid, m1_rvalid); end
    tick();
    rst_n = 1;
    clear_inputs();
  endtask

  task automatic test_rr_read;
    m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rr_c0_gnt got=%0b%0b exp=10", m0_gnt, m1_gnt); end
    checks++; if (mem_r_en !== 1'b1 || mem_r_addr !== 32'h10) begin errors++; $display("FAIL rr_c0_raddr got=%0b/%h exp=1/10", mem_r_en, mem_r_addr); end
    tick();
    m0_req = 0;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || mem_r_addr !== 32'h20) begin errors++; $display("FAIL rr_c1_m1 got=%0b/%h exp=1/20", m1_gnt, mem_r_addr); end
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== (32'h10 ^ KEY)) begin errors++; $display("FAIL rr_c1_m0_rdata got=%0b/%h exp=1/%h", m0_rvalid, m0_rdata, 32'h10 ^ KEY); end
    checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin errors++; $display("FAIL rr_c1_m1_quiet got=%0b/%h exp=0/0", m1_rvalid, m1_rdata); end
    tick();
    m1_req = 0;
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== (32'h20 ^ KEY)) begin errors++; $display("FAIL rr_c2_m1_rdata got=%0b/%h exp=1/%h", m1_rvalid, m1_rdata, 32'h20 ^ KEY); end
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL rr_c2_m0_quiet got=%0b/%h exp=0/0", m0_rvalid, m0_rdata); end
    tick();
  endtask

  task automatic test_write;
    m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt got=%0b%0b exp=01", m0_gnt, m1_gnt); end
    checks++; if (mem_w_en !== 1'b1 || mem_w_addr !== 32'h40) begin errors++; $display("FAIL wr_addr got=%0b/%h exp=1/40", mem_w_en, mem_w_addr); end
    checks++; if (mem_w_data !== 32'hDEADBEEF || mem_r_en !== 1'b0) begin errors++; $display("FAIL wr_data got=%h/%0b exp=deadbeef/0", mem_w_data, mem_r_en); end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b0 || mem_w_en !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got=%0b/%0b exp=0/0", m1_rvalid, mem_w_en); end
    tick();
  endtask

  task automatic test_lock;
    m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200;
    for (int i = 0; i < 3; i++) begin
      m0_lock = (i < 2);
      @(negedge clk);
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL lock_c%0d_gnt got=%0b%0b exp=10", i, m0_gnt, m1_gnt); end
      tick();
    end
    m0_req = 0; m0_lock = 0;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || mem_r_addr !== 32'h200) begin errors++; $display("FAIL lock_release_m1 got=%0b/%h exp=1/200", m1_gnt, mem_r_addr); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forced_release;
    m0_req = 1; m0_lock = 1; m0_addr = 32'h300; m1_req = 1; m1_addr = 32'h400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL force_c%0d_gnt got=%0b%0b exp=10", i, m0_gnt, m1_gnt); end
      tick();
    end
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin errors++; $display("FAIL force_c4_gnt got=%0b%0b exp=01", m0_gnt, m1_gnt); end
    tick();
    m1_req = 0;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL force_relock_gnt got=%0b exp=1", m0_gnt); end
    tick();
    m1_req = 1;
    @(negedge clk);
    checks++; if (m1_gnt !== 1'b0 || m0_gnt !== 1'b1) begin errors++; $display("FAIL force_relock_hold got=%0b%0b exp=10", m0_gnt, m1_gnt); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back;
    m0_req = 1; m0_addr = 32'h30;
    tick();
    m0_addr = 32'h31;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== (32'h30 ^ KEY)) begin errors++; $display("FAIL b2b_0_rdata got=%0b/%h exp=1/%h", m0_rvalid, m0_rdata, 32'h30 ^ KEY); end
    tick();
    m0_req = 0; m1_req = 1; m1_addr = 32'h50;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== (32'h31 ^ KEY)) begin errors++; $display("FAIL b2b_1_rdata got=%0b/%h exp=1/%h", m0_rvalid, m0_rdata, 32'h31 ^ KEY); end
    tick();
    m1_req = 0;
    @(negedge clk);
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== (32'h50 ^ KEY) || m0_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_2_rdata got=%0b/%h/%0b exp=1/%h/0", m1_rvalid, m1_rdata, m0_rvalid, 32'h50 ^ KEY); end
    tick();
  endtask

  task automatic test_reset_mid_read;
    m0_req = 1; m0_addr = 32'h60;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL rmr_gnt got=%0b exp=1", m0_gnt); end
    tick();
    rst_n = 0;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin errors++; $display("FAIL rmr_in_rst_rvalid got=%0b/%h exp=0/0", m0_rvalid, m0_rdata); end
    checks++; if (m0_gnt !== 1'b0 || mem_r_en !== 1'b0 || mem_r_addr !== 32'h0) begin errors++; $display("FAIL rmr_in_rst_out got=%0b/%0b/%h exp=0/0/0", m0_gnt, mem_r_en, mem_r_addr); end
    tick();
    rst_n = 1;
    m0_req = 0;
    @(negedge clk);
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rmr_post_rvalid got=%0b exp=0", m0_rvalid); end
    tick();
    m0_req = 1; m1_req = 1; m0_addr = 32'h70; m1_addr = 32'h80;
    @(negedge clk);
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin errors++; $display("FAIL rmr_first_rr got=%0b%0b exp=10", m0_gnt, m1_gnt); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_rr_read();
    test_write();
    test_lock();
    test_forced_release();
    test_back_to_back();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 16: max consecutive locked cycles one requester may hold the bus.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports m0_req / m1_req  input  1  access request (m0 = core data port, m1 = debug/loader port).
REQ-005 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports m0_lock / m1_lock  input  1  keep ownership after this access.
REQ-007 SHALL have ports m0_addr / m1_addr  input  32  word address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  32  write data.
REQ-009 SHALL have ports m0_gnt / m1_gnt  output  1  access accepted this cycle.
REQ-010 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid.
REQ-011 SHALL have ports m0_rdata / m1_rdata  output  32  read data.
REQ-012 SHALL have ports mem_r_en, mem_w_en  output  1  memory strobes.
REQ-013 SHALL have ports mem_r_addr, mem_w_addr, mem_w_data  output  32  memory address/data.
REQ-014 SHALL have port mem_r_data  input  32  memory read data, valid one cycle after mem_r_en.

Function
REQ-015 SHALL hold state machine {IDLE, OWN0, OWN1}, round-robin pointer last (0/1), lock counter lcnt (clog2(LOCK_MAX+1) bits), read tag rtag (valid + owner).
REQ-016 In IDLE, single requester SHALL be granted combinationally in the same cycle (mX_gnt = mX_req).
REQ-017 In IDLE with both requesting, SHALL grant the requester != last; the other sees gnt = 0 and must hold request stable.
REQ-018 On each grant, last SHALL update to the granted index at the clock edge.
REQ-019 At most one gnt SHALL be high per cycle; gnt SHALL never be high without its req.
REQ-020 Granted read SHALL drive mem_r_en = 1, mem_r_addr = mX_addr; granted write SHALL drive mem_w_en = 1, mem_w_addr = mX_addr, mem_w_data = mX_wdata; all mem outputs 0 when nothing granted.
REQ-021 Read latency SHALL be exactly 1 cycle: cycle after a granted read, mX_rvalid = 1 and mX_rdata = mem_r_data for the tagged owner only; non-owner rdata = 0 and rvalid = 0.
REQ-022 Writes SHALL produce no rvalid.
REQ-023 Grant with mX_lock = 1 SHALL move IDLE -> OWNX and load lcnt = 1.
REQ-024 In OWNX only mX SHALL be grantable; other requester stalls with gnt = 0.
REQ-025 In OWNX, lcnt SHALL increment each cycle, saturating at LOCK_MAX.
REQ-026 OWNX -> IDLE SHALL occur at the edge where mX_lock = 0, or where lcnt = LOCK_MAX (forced release); last = X on exit, so a waiting other requester wins next cycle.
REQ-027 Forced release SHALL be ignored by the locking requester's lock input until it returns to IDLE; re-lock is allowed via normal arbitration.
REQ-028 Both requesting with both locks high in IDLE: only the round-robin winner SHALL enter OWN.
REQ-029 Back-to-back reads by the same or alternating owners SHALL each return rvalid on the following cycle with no bubble.

Reset
REQ-030 rst_n low SHALL immediately force state = IDLE, last = 1, lcnt = 0, rtag invalid; all gnt, rvalid, mem strobes and all data/address outputs 0.
REQ-031 A read granted in the cycle before reset assertion SHALL produce no rvalid after reset release.
REQ-032 After release, first simultaneous request SHALL be granted to m0.

Verification
REQ-033 Reset release, m0 and m1 both read (m0_addr = 0x10, m1_addr = 0x20) -> cycle 0 m0_gnt, mem_r_addr = 0x10; cycle 1 m1_gnt, m0_rvalid with mem data; cycle 2 m1_rvalid.
REQ-034 m1 writes 0xDEADBEEF to 0x40 alone -> m1_gnt same cycle, mem_w_en = 1, mem_w_addr = 0x40, mem_w_data = 0xDEADBEEF, no rvalid.
REQ-035 m0 lock for 3 accesses while m1_req held -> m1_gnt = 0 for 3 cycles, m1 granted the cycle after m0_lock drops.
REQ-036 LOCK_MAX = 4, m0_lock stuck high, m1_req high -> m0 granted 4 cycles, then m1 granted on cycle 5.
REQ-037 rst_n asserted the cycle after a m0 read grant -> m0_rvalid stays 0, all outputs 0 during reset.
